psum_accumulator: RTL and testbench

// Downstream of the 16-MAC convolution array. Accumulates its per-chunk partial sums
// (one 16-channel x 3x3 group per beat) over all input-channel chunks of one output pixel.

---
 rtl/psum_accumulator.sv | 244 ++++++++++++++++++++++++
 tb/tb_psum_accumulator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator behind the 16-MAC convolution array: sums chunk psums per
// output pixel, adds bias, optional ReLU, rounds half-up and saturates to Q2.14.
module psum_accumulator #(
   parameter int DATA_W  = 16,
   parameter int FRAC_W  = 14,
   parameter int IN_W    = 40,
   parameter int CHUNK_W = 8,
   parameter int PIX_W   = 16,
   parameter int ACC_W   = IN_W + CHUNK_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [CHUNK_W-1:0] cfg_num_chunks,
   input  logic [PIX_W-1:0]   cfg_num_pixels,
   input  logic [DATA_W-1:0]  cfg_bias,
   input  logic               cfg_relu,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_psum,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               busy,
   output logic               done,
   output logic               sat_flag
);

   // One extra bit so accumulator plus shifted bias can never wrap
   localparam int V_W = ACC_W + 1;
   localparam logic signed [V_W-1:0] SAT_MAX = V_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [V_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic signed [V_W-1:0] RND     = V_W'(64'sd1 <<< (FRAC_W - 1));

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      POST   = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [ACC_W-1:0]    acc;
   logic [CHUNK_W-1:0]  chunk_cnt;
   logic [PIX_W-1:0]    pix_cnt;
   logic [CHUNK_W-1:0]  chunk_last;
   logic [PIX_W-1:0]    pix_last;
   logic [DATA_W-1:0]   bias;
   logic                relu;
   logic                beat;
   logic                out_fire;
   logic                last_chunk;
   logic                last_pix;
   logic                in_ready_nxt;
   logic                busy_nxt;
   logic                done_nxt;
   logic [DATA_W:0]     post_res;
   logic [ACC_W-1:0]    psum_ext;

   // Bias add, round half up, optional ReLU and saturation; returns {clamped, data}
   function automatic logic [DATA_W:0] post_process(
      input logic [ACC_W-1:0]  acc_in,
      input logic [DATA_W-1:0] bias_in,
      input logic              relu_in
   );
      logic signed [V_W-1:0] v;
      logic signed [V_W-1:0] b;
      logic signed [V_W-1:0] r;
      logic [DATA_W:0]       res;
      v = $signed({acc_in[ACC_W-1], acc_in});
      b = $signed({{(V_W - DATA_W){bias_in[DATA_W-1]}}, bias_in});
      v = v + (b <<< FRAC_W);
      r = (v + RND) >>> FRAC_W;
      r = (relu_in && r[V_W-1]) ? '0 : r;
      if (r > SAT_MAX) begin
         res = {1'b1, SAT_MAX[DATA_W-1:0]};
      end else if (r < SAT_MIN) begin
         res = {1'b1, SAT_MIN[DATA_W-1:0]};
      end else begin
         res = {1'b0, r[DATA_W-1:0]};
      end
      return res;
   endfunction

   assign beat       = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;
   assign last_chunk = (chunk_cnt == chunk_last);
   assign last_pix   = (pix_cnt == pix_last);
   assign psum_ext   = {{(ACC_W - IN_W){in_psum[IN_W-1]}}, in_psum};

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start && (cfg_num_pixels != {PIX_W{1'b0}})) begin
               next_state = ACCUM;
            end else begin
               next_state = IDLE;
            end
         end
         ACCUM: begin
            if (beat && last_chunk) begin
               next_state = POST;
            end else begin
               next_state = ACCUM;
            end
         end
         POST: begin
            next_state = OUTPUT;
         end
         OUTPUT: begin
            if (out_fire) begin
               next_state = last_pix ? IDLE : ACCUM;
            end else begin
               next_state = OUTPUT;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Control outputs, decoded from the upcoming state so they can be registered
   always_comb begin
      in_ready_nxt = (next_state == ACCUM);
      busy_nxt     = (next_state != IDLE);
      done_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (start && (cfg_num_pixels == {PIX_W{1'b0}})) begin
               done_nxt = 1'b1;
            end else begin
               done_nxt = 1'b0;
            end
         end
         OUTPUT: begin
            if (out_fire && last_pix) begin
               done_nxt = 1'b1;
            end else begin
               done_nxt = 1'b0;
            end
         end
         default: begin
            done_nxt = 1'b0;
         end
      endcase
   end

   // Result of the POST stage
   always_comb begin
      post_res = post_process(acc, bias, relu);
   end

   // Registered control outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         in_ready <= in_ready_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   // Configuration, accumulator, counters and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc        <= '0;
         chunk_cnt  <= '0;
         pix_cnt    <= '0;
         chunk_last <= '0;
         pix_last   <= '0;
         bias       <= '0;
         relu       <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         sat_flag   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // A chunk count of zero behaves as a single chunk
                  chunk_last <= (cfg_num_chunks == {CHUNK_W{1'b0}}) ?
                                {CHUNK_W{1'b0}} : (cfg_num_chunks - {{(CHUNK_W-1){1'b0}}, 1'b1});
                  pix_last   <= cfg_num_pixels - {{(PIX_W-1){1'b0}}, 1'b1};
                  bias       <= cfg_bias;
                  relu       <= cfg_relu;
                  acc        <= '0;
                  chunk_cnt  <= '0;
                  pix_cnt    <= '0;
                  sat_flag   <= 1'b0;
               end else begin
                  acc <= acc;
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc       <= acc + psum_ext;
                  chunk_cnt <= chunk_cnt + {{(CHUNK_W-1){1'b0}}, 1'b1};
               end else begin
                  acc <= acc;
               end
            end
            POST: begin
               out_data  <= post_res[DATA_W-1:0];
               out_valid <= 1'b1;
               if (post_res[DATA_W]) begin
                  sat_flag <= 1'b1;
               end else begin
                  sat_flag <= sat_flag;
               end
            end
            OUTPUT: begin
               if (out_fire) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  chunk_cnt <= '0;
                  pix_cnt   <= pix_cnt + {{(PIX_W-1){1'b0}}, 1'b1};
               end else begin
                  out_valid <= out_valid;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized self-checking bench for psum_accumulator against an arithmetic reference.
module tb_psum_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  cfg_num_chunks;
   logic [15:0] cfg_num_pixels;
   logic [15:0] cfg_bias;
   logic        cfg_relu;
   logic        in_valid;
   logic        in_ready;
   logic [39:0] in_psum;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;
   logic        done;
   logic        sat_flag;

   int     checks = 0;
   int     errors = 0;
   longint dir_q[$];

   always #5 clk = ~clk;

   psum_accumulator dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_num_chunks(cfg_num_chunks), .cfg_num_pixels(cfg_num_pixels),
      .cfg_bias(cfg_bias), .cfg_relu(cfg_relu),
      .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done), .sat_flag(sat_flag)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: real-valued sum plus bias, floor((v + half)/2^14), relu, clamp to int16
   function automatic longint ref_pix(input longint sum, input logic [15:0] b,
                                      input bit relu, output bit sat);
      longint v, q;
      v = sum + longint'($signed(b)) * 64'sd16384 + 64'sd8192;
      q = v / 64'sd16384;
      if (v < 0 && (v % 64'sd16384) != 0) q = q - 1;
      if (relu && q < 0) q = 0;
      sat = 1'b0;
      if (q > 32767) begin
         q = 32767; sat = 1'b1;
      end else if (q < -32768) begin
         q = -32768; sat = 1'b1;
      end
      return q;
   endfunction

   function automatic longint rand_psum();
      longint p;
      if ($urandom_range(0, 3) == 0) begin
         p = longint'({$urandom, $urandom});
         p = (p <<< 24) >>> 24;
      end else begin
         p = longint'($urandom_range(0, 32'h3FFF_FFFF)) - 64'sd536870912;
      end
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_cfg();
      cfg_num_chunks = 8'($urandom);
      cfg_num_pixels = 16'($urandom);
      cfg_bias       = 16'($urandom);
      cfg_relu       = 1'($urandom);
   endtask

   task automatic run_job(input int chunks, input int pixels, input logic [15:0] b,
                          input bit relu, input int stall0, input bit poke);
      int       ce, idx, tmo;
      longint   psq[$];
      longint   sum, expv;
      bit       sat_any, s;
      logic [15:0] held;
      ce = (chunks == 0) ? 1 : chunks;
      for (int i = 0; i < ce * pixels; i++) begin
         if (dir_q.size() > 0) psq.push_back(dir_q.pop_front());
         else psq.push_back(rand_psum());
      end
      cfg_num_chunks = 8'(chunks);
      cfg_num_pixels = 16'(pixels);
      cfg_bias       = b;
      cfg_relu       = relu;
      start = 1'b1;
      tick();
      start = 1'b0;
      scramble_cfg();
      check("busy_after_start", busy, 1);
      check("sat_cleared", sat_flag, 0);
      check("in_ready_accum", in_ready, 1);
      sat_any = 1'b0;
      for (int p = 0; p < pixels; p++) begin
         sum = 0;
         for (int c = 0; c < ce; c++) begin
            if ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               repeat ($urandom_range(1, 2)) tick();
            end
            idx = p * ce + c;
            in_valid = 1'b1;
            in_psum  = psq[idx][39:0];
            sum += psq[idx];
            tmo = 0;
            while (!in_ready && tmo < 50) begin
               tick();
               tmo++;
            end
            if (tmo >= 50) check("in_ready_timeout", 0, 1);
            tick();
         end
         // Keep offering the next beat while the result is pending; it must not be taken
         idx = (p + 1) * ce;
         if (idx < psq.size()) begin
            in_valid = 1'b1;
            in_psum  = psq[idx][39:0];
         end else begin
            in_valid = 1'b0;
         end
         check("post_no_valid", out_valid, 0);
         check("post_no_ready", in_ready, 0);
         if (poke && p == 0) begin
            start = 1'b1;
            cfg_num_pixels = 16'd0;
         end
         tick();
         start = 1'b0;
         check("out_valid_latency", out_valid, 1);
         expv = ref_pix(sum, b, relu, s);
         sat_any |= s;
         check("out_data", longint'($signed(out_data)), expv);
         held = out_data;
         out_ready = 1'b0;
         repeat ((p == 0) ? stall0 : 0) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held);
            check("stall_in_ready", in_ready, 0);
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         check("valid_drop", out_valid, 0);
         if (p == pixels - 1) begin
            check("done_pulse", done, 1);
            check("busy_end", busy, 0);
            check("sat_flag", sat_flag, longint'(sat_any));
         end else begin
            check("no_done", done, 0);
            check("back_to_accum", in_ready, 1);
         end
      end
      in_valid = 1'b0;
      tick();
      check("done_single", done, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_sat"}, sat_flag, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_psum = '0; out_ready = 1'b0;
      cfg_num_chunks = '0; cfg_num_pixels = '0; cfg_bias = '0; cfg_relu = 1'b0;
      tick(); tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      dir_q = '{64'sd268435456};
      run_job(1, 1, 16'h0000, 1'b0, 0, 1'b0);
      dir_q = '{64'sd268435456, 64'sd268435456, 64'sd268435456};
      run_job(3, 1, 16'h0000, 1'b0, 0, 1'b0);
      check("sat_sticky", sat_flag, 1);
      dir_q = '{-64'sd268435456};
      run_job(1, 1, 16'h2000, 1'b0, 0, 1'b0);
      dir_q = '{-64'sd268435456};
      run_job(1, 1, 16'h2000, 1'b1, 0, 1'b0);
      dir_q = '{64'sd8192, 64'sd8191, -64'sd8192, -64'sd8193};
      run_job(1, 4, 16'h0000, 1'b0, 0, 1'b0);

      // Zero-pixel start: done next cycle, stays idle
      cfg_num_pixels = 16'd0; cfg_num_chunks = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      check("zero_pix_done", done, 1);
      check("zero_pix_busy", busy, 0);
      tick();
      check("zero_pix_done_clr", done, 0);

      run_job(0, 2, 16'($urandom), 1'b0, 0, 1'b0);
      run_job(2, 2, 16'($urandom), 1'b0, 5, 1'b0);

      // Reset in the middle of a job
      cfg_num_chunks = 8'd2; cfg_num_pixels = 16'd4; start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_psum = 40'h00_1000_0000;
      tick();
      in_valid = 1'b0; rst_n = 1'b0;
      tick();
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      tick();
      run_job(2, 4, 16'($urandom), 1'($urandom), 2, 1'b1);

      for (int j = 0; j < 10; j++) begin
         run_job($urandom_range(1, 5), $urandom_range(1, 4), 16'($urandom),
                 1'($urandom), $urandom_range(0, 3), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
